seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle integer divider for the RV32M/RV64M execute stage. It replaces the fully unrolled combinational 32-bit array divider with an iterative restoring divider that retires `UNROLL` quotient bits per clock. It uses a valid/ready handshake and a pipeline flush, and implements the RISC-V divide-by-zero and signed-overflow results. Sits beside the ALU, and the execute-stage control stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, default 32: operand and result width; any even value ≥ 4.
- `UNROLL`, default 1: quotient bits resolved per cycle; must divide `WIDTH`; `N = WIDTH/UNROLL` iteration cycles.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept a request; equals (state == IDLE).
- `dividend` input WIDTH: numerator.
- `divisor` input WIDTH: denominator.
- `sign` input 1: 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
- `flush` input 1: synchronous kill of any request in flight.
- `out_valid` output 1: result valid, held until it is taken.
- `out_ready` input 1: consumer takes the result.
- `quotient` output WIDTH: registered quotient.
- `remainder` output WIDTH: registered remainder.
- `div_by_zero` output 1: registered; the divisor was 0.
- `overflow` output 1: registered; signed −2^(WIDTH−1) / −1.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- IDLE:
  - On `in_valid && in_ready && !flush`, latch `sign`, the operand sign bits, the absolute values of both operands, and the special-case flags.
  - Absolute values are unsigned WIDTH bits, so |−2^(WIDTH−1)| is representable.
  - If `divisor == 0` or overflow, go directly to DONE. Otherwise go to CALC with `count = 0`.
- CALC:
  - Each edge performs `UNROLL` restoring steps. Each step shifts the next dividend MSB into a WIDTH+1-bit partial remainder and subtracts |divisor|.
  - If the difference is non-negative, keep it and the quotient bit is 1. Otherwise restore the partial remainder and the quotient bit is 0.
  - `count` increments each edge. The edge where `count == N−1` also applies the sign fix-up, loads `quotient`/`remainder`, and enters DONE.
- Sign rules (signed mode):
  - The quotient truncates toward zero and is negated iff the operand signs differ.
  - The remainder takes the sign of the dividend.
  - The identity `dividend = quotient*divisor + remainder` always holds (mod 2^WIDTH).
- Divide by zero: `quotient` = all ones, `remainder = dividend` (original, unmodified), `div_by_zero = 1`. This applies in both signed and unsigned modes.
- Signed overflow (`sign=1`, dividend = 100…0, divisor = all ones): `quotient = dividend`, `remainder = 0`, `overflow = 1`. In unsigned mode the same operands divide normally.
- DONE:
  - `out_valid = 1`. Outputs and flags are stable.
  - On `out_ready`, go to IDLE. A new request cannot be accepted in this cycle because `in_ready = 0`.
- Flush:
  - Highest priority. The next edge goes to IDLE from any state, with `out_valid = 0` and the result discarded.
  - A request presented in the same cycle as `flush` is not accepted.
  - Output data registers keep their old values.

## Timing
- Reset (async assert, any state):
  - State goes to IDLE; `count`, `quotient`, `remainder`, `div_by_zero` and `overflow` go to 0; `out_valid = 0`.
  - `in_ready = 1` while in reset and after release.
- Normal request accepted at edge k: `out_valid` is high after edge k+N+1 (k+1 is the latch edge, followed by N CALC edges).
  - WIDTH=32, UNROLL=1 gives 33 cycles.
- Special case (zero divisor or overflow) accepted at edge k: `out_valid` is high after edge k+1.
- Result taken at edge m (`out_valid && out_ready`): `in_ready = 1` after edge m. The earliest next acceptance is edge m+1.
- `out_ready` held low: DONE persists indefinitely with all outputs unchanged.
- Reset or flush mid-CALC: no `out_valid` pulse for the killed operation. The next request behaves exactly as it would after reset.
- `out_valid`, `quotient`, `remainder` and the flags are all register outputs. `in_ready` is decoded from the state register only, with no input-to-output combinational path.

## Test plan
- Unsigned `100/7`, WIDTH=32, UNROLL=1 → `quotient=14`, `remainder=2`, flags 0. `out_valid` rises exactly 33 cycles after acceptance.
- Signed `0xFFFFFFF9/2` (−7/2) → `0xFFFFFFFD`, `0xFFFFFFFF`. Signed `7/0xFFFFFFFE` (7/−2) → `0xFFFFFFFD`, `1`.
- `0x12345678/0` with `sign=1` and then `sign=0` → `quotient=0xFFFFFFFF`, `remainder=0x12345678`, `div_by_zero=1`, `out_valid` one cycle after acceptance.
- `0x80000000/0xFFFFFFFF`:
  - signed → `quotient=0x80000000`, `remainder=0`, `overflow=1`, 1-cycle latency;
  - unsigned → `quotient=0`, `remainder=0x80000000`, 33 cycles.
- Backpressure and flush:
  - Hold `out_ready` low for 5 cycles → outputs stable and `in_ready=0` throughout; taking the result returns `in_ready=1` next cycle.
  - `flush` on CALC cycle 10 → no `out_valid`; a following `9/3` gives `3`, `0`.
  - Repeat with `rst_n` pulsed mid-CALC → same recovery.
- WIDTH=8, UNROLL=2: `200/3` → `66`, `2`, `out_valid` 5 cycles after acceptance. A random sweep against a reference model covers both modes.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring integer divider (RV32M/RV64M DIV/DIVU/REM/REMU) retiring UNROLL
// quotient bits per clock, with valid/ready handshake, flush and RISC-V special cases.
module seq_divider #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             sign,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N     = WIDTH / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             sign_r, dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_sh, abs_dvs, dvd_sh_nxt;
  logic [WIDTH:0]   prem, prem_nxt;
  logic             step_q;
  logic             accept, is_zero, is_ovf, last;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? ('0 - x) : x;
  endfunction

  assign accept  = in_valid && in_ready && !flush;
  assign is_zero = (divisor == '0);
  assign is_ovf  = sign && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  assign last    = (count == CNT_W'(N - 1));

  // dvd_sh shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    dvd_sh_nxt = dvd_sh;
    prem_nxt   = prem;
    step_q     = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      prem_nxt = {prem_nxt[WIDTH-1:0], dvd_sh_nxt[WIDTH-1]};
      step_q   = (prem_nxt >= {1'b0, abs_dvs});
      if (step_q) prem_nxt = prem_nxt - {1'b0, abs_dvs};
      dvd_sh_nxt = {dvd_sh_nxt[WIDTH-2:0], step_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_zero || is_ovf) ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // Control and architecturally visible result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (accept)              count <= '0;
      else if (state == CALC)  count <= count + CNT_W'(1);
      if (accept && is_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
      end else if (accept && is_ovf) begin
        quotient    <= dividend;
        remainder   <= '0;
        div_by_zero <= 1'b0;
        overflow    <= 1'b1;
      end else if (state == CALC && last && !flush) begin
        quotient    <= cond_neg(dvd_sh_nxt, sign_r && (dvd_neg ^ dvs_neg));
        remainder   <= cond_neg(prem_nxt[WIDTH-1:0], sign_r && dvd_neg);
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
    end
  end

  // Working datapath; contents are don't-care outside CALC so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r  <= sign;
      dvd_neg <= sign && dividend[WIDTH-1];
      dvs_neg <= sign && divisor[WIDTH-1];
      dvd_sh  <= cond_neg(dividend, sign && dividend[WIDTH-1]);
      abs_dvs <= cond_neg(divisor, sign && divisor[WIDTH-1]);
      prem    <= '0;
    end else if (state == CALC) begin
      dvd_sh  <= dvd_sh_nxt;
      prem    <= prem_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios on a 32-bit/UNROLL=1 and an 8-bit/UNROLL=2
// instance plus a randomized sweep against an arithmetic reference model.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_sign, a_flush, a_out_valid, a_out_ready, a_dbz, a_ovf;
  logic [31:0] a_dividend, a_divisor, a_quotient, a_remainder;
  logic        b_in_valid, b_in_ready, b_sign, b_flush, b_out_valid, b_out_ready, b_dbz, b_ovf;
  logic [7:0]  b_dividend, b_divisor, b_quotient, b_remainder;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(32), .UNROLL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .dividend(a_dividend), .divisor(a_divisor), .sign(a_sign), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .quotient(a_quotient),
    .remainder(a_remainder), .div_by_zero(a_dbz), .overflow(a_ovf));

  seq_divider #(.WIDTH(8), .UNROLL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dividend(b_dividend), .divisor(b_divisor), .sign(b_sign), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .quotient(b_quotient),
    .remainder(b_remainder), .div_by_zero(b_dbz), .overflow(b_ovf));

  // Reference: RISC-V division semantics using native / and % on 64-bit values
  function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic s, output logic [63:0] q, output logic [63:0] r,
                                  output logic dz, output logic ov);
    logic [63:0] m;
    longint sa, sb;
    m  = (64'd1 << w) - 64'd1;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 64'd0) begin
      q = m; r = a; dz = 1'b1;
    end else if (s && a == (64'd1 << (w - 1)) && b == m) begin
      q = a; r = 64'd0; ov = 1'b1;
    end else if (s) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      q  = 64'(sa / sb) & m;
      r  = 64'(sa % sb) & m;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  task automatic do_a(input logic [31:0] x, input logic [31:0] y, input logic s,
                      output logic [65:0] res, output int lat);
    a_dividend = x; a_divisor = y; a_sign = s; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = {a_quotient, a_remainder, a_dbz, a_ovf};
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic do_b(input logic [7:0] x, input logic [7:0] y, input logic s,
                      output logic [17:0] res, output int lat);
    b_dividend = x; b_divisor = y; b_sign = s; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    res = {b_quotient, b_remainder, b_dbz, b_ovf};
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    {a_in_valid, a_sign, a_flush, a_out_ready, a_dividend, a_divisor} = '0;
    {b_in_valid, b_sign, b_flush, b_out_ready, b_dividend, b_divisor} = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_in_ready, a_out_valid, a_quotient, a_remainder, a_dbz, a_ovf} !== {2'b10, 66'd0}) begin
      n_fail++;
      $display("FAIL reset_a_in_reset got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b want rdy=1 rest 0",
               a_in_ready, a_out_valid, a_quotient, a_remainder, a_dbz, a_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({a_in_ready, a_out_valid, a_quotient, a_remainder, a_dbz, a_ovf} !== {2'b10, 66'd0}) begin
      n_fail++;
      $display("FAIL reset_a_after got rdy=%b vld=%b q=%h r=%h want rdy=1 rest 0",
               a_in_ready, a_out_valid, a_quotient, a_remainder);
    end
    n_cmp++;
    if ({b_in_ready, b_out_valid, b_quotient, b_remainder, b_dbz, b_ovf} !== {2'b10, 18'd0}) begin
      n_fail++;
      $display("FAIL reset_b_after got rdy=%b vld=%b q=%h r=%h want rdy=1 rest 0",
               b_in_ready, b_out_valid, b_quotient, b_remainder);
    end
  endtask

  task automatic test_directed;
    logic [31:0] xs [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h12345678, 32'h12345678,
                            32'h80000000, 32'h80000000};
    logic [31:0] ys [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        ss [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [65:0] ex [7] = '{{32'd14, 32'd2, 2'b00}, {32'hFFFFFFFD, 32'hFFFFFFFF, 2'b00},
                            {32'hFFFFFFFD, 32'd1, 2'b00}, {32'hFFFFFFFF, 32'h12345678, 2'b10},
                            {32'hFFFFFFFF, 32'h12345678, 2'b10}, {32'h80000000, 32'd0, 2'b01},
                            {32'd0, 32'h80000000, 2'b00}};
    int          el [7] = '{33, 33, 33, 1, 1, 1, 33};
    logic [65:0] res;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      do_a(xs[i], ys[i], ss[i], res, lat);
      n_cmp++;
      if (res !== ex[i]) begin
        n_fail++;
        $display("FAIL directed_%0d result got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                 i, res[65:34], res[33:2], res[1], res[0], ex[i][65:34], ex[i][33:2], ex[i][1], ex[i][0]);
      end
      n_cmp++;
      if (lat !== el[i]) begin
        n_fail++;
        $display("FAIL directed_%0d latency got %0d want %0d", i, lat, el[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [65:0] snap;
    int          lat;
    a_dividend = 32'd100; a_divisor = 32'd7; a_sign = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    snap = {a_quotient, a_remainder, a_dbz, a_ovf};
    n_cmp++;
    if (snap !== {32'd14, 32'd2, 2'b00}) begin
      n_fail++;
      $display("FAIL bp_result got q=%h r=%h want q=e r=2", snap[65:34], snap[33:2]);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_quotient, a_remainder, a_dbz, a_ovf} !== {2'b10, snap}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b q=%h r=%h want vld=1 rdy=0 q=%h r=%h",
                 i, a_out_valid, a_in_ready, a_quotient, a_remainder, snap[65:34], snap[33:2]);
      end
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    n_cmp++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_take got rdy=%b vld=%b want rdy=1 vld=0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_kill(input bit use_reset);
    logic [65:0] prev, res;
    int          lat;
    bit          seen;
    prev = {a_quotient, a_remainder, a_dbz, a_ovf};
    a_dividend = 32'd1000; a_divisor = 32'd3; a_sign = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    if (use_reset) begin
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL rst_mid_async got vld=%b rdy=%b want vld=0 rdy=1", a_out_valid, a_in_ready);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      a_flush = 1'b1;
      @(posedge clk); #1;
      a_dividend = 32'd5; a_divisor = 32'd0; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_flush = 1'b0; a_in_valid = 1'b0;
      n_cmp++;
      if ({a_in_ready, a_out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL flush_blocks_accept got rdy=%b vld=%b want rdy=1 vld=0", a_in_ready, a_out_valid);
      end
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (a_out_valid) seen = 1'b1; end
    n_cmp++;
    if ({seen, a_in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL kill_%0d_no_valid got seen=%b rdy=%b want seen=0 rdy=1", use_reset, seen, a_in_ready);
    end
    n_cmp++;
    if ({a_quotient, a_remainder, a_dbz, a_ovf} !== (use_reset ? 66'd0 : prev)) begin
      n_fail++;
      $display("FAIL kill_%0d_data got q=%h r=%h want q=%h r=%h", use_reset, a_quotient, a_remainder,
               use_reset ? 32'd0 : prev[65:34], use_reset ? 32'd0 : prev[33:2]);
    end
    do_a(32'd9, 32'd3, 1'b0, res, lat);
    n_cmp++;
    if ({res, lat} !== {32'd3, 32'd0, 2'b00, 32'd33}) begin
      n_fail++;
      $display("FAIL kill_%0d_recover got q=%h r=%h lat=%0d want q=3 r=0 lat=33",
               use_reset, res[65:34], res[33:2], lat);
    end
  endtask

  task automatic test_narrow;
    logic [17:0] res;
    int          lat;
    do_b(8'd200, 8'd3, 1'b0, res, lat);
    n_cmp++;
    if ({res, lat} !== {8'd66, 8'd2, 2'b00, 32'd5}) begin
      n_fail++;
      $display("FAIL narrow_200_3 got q=%0d r=%0d lat=%0d want q=66 r=2 lat=5", res[17:10], res[9:2], lat);
    end
  endtask

  task automatic test_random;
    logic [7:0]  x8, y8;
    logic [31:0] x32, y32;
    logic        s, dz, ov;
    logic [63:0] q, r;
    logic [17:0] res8;
    logic [65:0] res32;
    int          lat, sel;
    for (int i = 0; i < 300; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); s = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) y8 = 8'd0;
      else if (sel == 1) begin x8 = 8'h80; y8 = 8'hFF; end
      else if (sel == 2) y8 = 8'($urandom_range(1, 3));
      ref_div(8, {56'd0, x8}, {56'd0, y8}, s, q, r, dz, ov);
      do_b(x8, y8, s, res8, lat);
      n_cmp++;
      if ({res8, lat} !== {q[7:0], r[7:0], dz, ov, ((dz || ov) ? 32'd1 : 32'd5)}) begin
        n_fail++;
        $display("FAIL rand8 %h/%h s=%b got q=%h r=%h f=%b%b lat=%0d want q=%h r=%h f=%b%b",
                 x8, y8, s, res8[17:10], res8[9:2], res8[1], res8[0], lat, q[7:0], r[7:0], dz, ov);
      end
    end
    for (int i = 0; i < 40; i++) begin
      x32 = $urandom; y32 = $urandom; s = 1'($urandom);
      sel = $urandom_range(0, 5);
      if (sel == 0) y32 = 32'd0;
      else if (sel == 1) y32 = y32 >> $urandom_range(8, 30);
      ref_div(32, {32'd0, x32}, {32'd0, y32}, s, q, r, dz, ov);
      do_a(x32, y32, s, res32, lat);
      n_cmp++;
      if ({res32, lat} !== {q[31:0], r[31:0], dz, ov, ((dz || ov) ? 32'd1 : 32'd33)}) begin
        n_fail++;
        $display("FAIL rand32 %h/%h s=%b got q=%h r=%h f=%b%b lat=%0d want q=%h r=%h f=%b%b",
                 x32, y32, s, res32[65:34], res32[33:2], res32[1], res32[0], lat, q[31:0], r[31:0], dz, ov);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_kill(1'b0);
    test_kill(1'b1);
    test_narrow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
